// File: rtl/fifo_port_arb_pkg.sv
// Shared state encoding and constants for the SDIO/SPI FIFO port arbiter.
package fifo_port_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ASSERT,
        RELEASE,
        SETTLE,
        DONE
    } state_t;

    localparam int WR    = 0;
    localparam int RD    = 1;
    localparam int TMO_W = 8;

endpackage

// File: rtl/fifo_port_arb_if.sv
// Requester and FIFO-side signal bundle of fifo_port_arb; slave = arbiter view.
interface fifo_port_arb_if #(
    parameter int dw = 8,
    parameter int aw = 4
);
    logic          wr_req;
    logic [dw-1:0] wr_dat;
    logic          wr_ack;
    logic          wr_err;
    logic          rd_req;
    logic [dw-1:0] rd_dat;
    logic          rd_ack;
    logic          rd_err;
    logic          fifo_ien;
    logic          fifo_oen;
    logic [dw-1:0] fifo_idat;
    logic [dw-1:0] fifo_odat;
    logic          fifo_full_n;
    logic          fifo_empty_n;
    logic [aw-1:0] lvl;
    logic          busy;

    modport slave (
        input  wr_req, wr_dat, rd_req, fifo_odat, fifo_full_n, fifo_empty_n,
        output wr_ack, wr_err, rd_dat, rd_ack, rd_err,
        output fifo_ien, fifo_oen, fifo_idat, lvl, busy
    );

    modport master (
        output wr_req, wr_dat, rd_req, fifo_odat, fifo_full_n, fifo_empty_n,
        input  wr_ack, wr_err, rd_dat, rd_ack, rd_err,
        input  fifo_ien, fifo_oen, fifo_idat, lvl, busy
    );
endinterface

// File: rtl/fifo_port_arb_rr_arb2.sv
// Two-way round-robin arbiter; remembers the last granted port (reset: read).
module rr_arb2
    import fifo_port_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] eligible,
    input  logic       last_gnt,
    input  logic       upd_en,
    output logic [1:0] grant,
    output logic       valid
);

    logic last_rd;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            last_rd <= 1'b1;
        else if (upd_en)
            last_rd <= last_gnt;
    end

    // On a tie the port that did not win last time goes first.
    always_comb begin
        grant = 2'b00;
        if (eligible[WR] && (!eligible[RD] || last_rd))
            grant[WR] = 1'b1;
        else if (eligible[RD])
            grant[RD] = 1'b1;
    end

    assign valid = |eligible;

endmodule

// File: rtl/fifo_port_arb.sv
// Arbiter and push/pop strobe sequencer for the shared SDIO/SPI byte FIFO.
// Optional stall timeout is built when FIFO_PORT_ARB_TIMEOUT_EN is defined.
//
// state   | meaning
// IDLE    | sample flags/requests, arbitrate
// ASSERT  | granted strobe high, write byte on fifo_idat
// RELEASE | strobe low; FIFO acts at end of this cycle
// SETTLE  | FIFO flags and read data valid, captured at end
// DONE    | ack pulse, lvl and last-grant updated
module fifo_port_arb
    import fifo_port_arb_pkg::*;
#(
    parameter int dw  = 8,
    parameter int aw  = 4,
    parameter int tmo = 256,
    parameter int tw  = TMO_W
) (
    input  logic           clk,
    input  logic           rst,
    fifo_port_arb_if.slave bus
);

    state_t        state_q, state_d;
    logic [1:0]    eligible, grant;
    logic          arb_valid, gnt_rd, idle;
    logic          wr_abort, rd_abort, wr_err_q, rd_err_q;
    logic          fifo_ien_q, fifo_oen_q, wr_ack_q, rd_ack_q;
    logic [dw-1:0] fifo_idat_q, rd_dat_q;
    logic [aw-1:0] lvl_q;

    assign idle = (state_q == IDLE);

    // A port whose abort pulse is in flight is held off for that cycle.
    assign eligible[WR] = idle & bus.wr_req & bus.fifo_full_n  & ~wr_err_q;
    assign eligible[RD] = idle & bus.rd_req & bus.fifo_empty_n & ~rd_err_q;

    rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .eligible (eligible),
        .last_gnt (gnt_rd),
        .upd_en   (state_q == DONE),
        .grant    (grant),
        .valid    (arb_valid)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (arb_valid) state_d = ASSERT;
            ASSERT:  state_d = RELEASE;
            RELEASE: state_d = SETTLE;
            SETTLE:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fifo_ien_q  <= 1'b0;
            fifo_oen_q  <= 1'b0;
            fifo_idat_q <= '0;
            gnt_rd      <= 1'b0;
            wr_ack_q    <= 1'b0;
            rd_ack_q    <= 1'b0;
            rd_dat_q    <= '0;
            lvl_q       <= '0;
        end else begin
            fifo_ien_q <= grant[WR];
            fifo_oen_q <= grant[RD];
            if (grant[WR])
                fifo_idat_q <= bus.wr_dat;
            if (arb_valid)
                gnt_rd <= grant[RD];
            wr_ack_q <= ((state_q == SETTLE) && !gnt_rd) || wr_abort;
            rd_ack_q <= ((state_q == SETTLE) &&  gnt_rd) || rd_abort;
            if (state_q == SETTLE) begin
                if (gnt_rd) begin
                    rd_dat_q <= bus.fifo_odat;
                    lvl_q    <= lvl_q - 1'b1;
                end else begin
                    lvl_q    <= lvl_q + 1'b1;
                end
            end
        end
    end

`ifdef FIFO_PORT_ARB_TIMEOUT_EN
    logic [tw-1:0] wr_cnt, rd_cnt;
    logic          wr_stall, rd_stall;

    assign wr_stall = idle & bus.wr_req & ~bus.fifo_full_n  & ~wr_err_q;
    assign rd_stall = idle & bus.rd_req & ~bus.fifo_empty_n & ~rd_err_q;
    assign wr_abort = wr_stall & (wr_cnt == tw'(tmo - 1));
    assign rd_abort = rd_stall & (rd_cnt == tw'(tmo - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_cnt   <= '0;
            rd_cnt   <= '0;
            wr_err_q <= 1'b0;
            rd_err_q <= 1'b0;
        end else begin
            wr_err_q <= wr_abort;
            rd_err_q <= rd_abort;
            if (!bus.wr_req || grant[WR] || wr_abort)
                wr_cnt <= '0;
            else if (wr_stall)
                wr_cnt <= wr_cnt + 1'b1;
            if (!bus.rd_req || grant[RD] || rd_abort)
                rd_cnt <= '0;
            else if (rd_stall)
                rd_cnt <= rd_cnt + 1'b1;
        end
    end
`else
    logic unused_cfg;

    assign wr_abort   = 1'b0;
    assign rd_abort   = 1'b0;
    assign wr_err_q   = 1'b0;
    assign rd_err_q   = 1'b0;
    assign unused_cfg = ^{tmo, tw};
`endif

    assign bus.fifo_ien  = fifo_ien_q;
    assign bus.fifo_oen  = fifo_oen_q;
    assign bus.fifo_idat = fifo_idat_q;
    assign bus.wr_ack    = wr_ack_q;
    assign bus.rd_ack    = rd_ack_q;
    assign bus.wr_err    = wr_err_q;
    assign bus.rd_err    = rd_err_q;
    assign bus.rd_dat    = rd_dat_q;
    assign bus.lvl       = lvl_q;
    assign bus.busy      = ~idle;

endmodule

// File: tb/tb_fifo_port_arb.sv
// Directed bench for fifo_port_arb against a behavioural 15-entry falling-edge FIFO.
// Building with FIFO_PORT_ARB_TIMEOUT_EN also exercises the stall timeout (tmo=16).
module tb_fifo_port_arb;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   int   n, cnt_a, cnt_b, cnt_c, acks, rd_n;
   int   ack_cyc [4];
   logic ack_rd  [4];

   always #5 clk = ~clk;

   fifo_port_arb_if #(.dw(8), .aw(4)) bus ();

   fifo_port_arb #(.dw(8), .aw(4), .tmo(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Behavioural FIFO: acts on strobe falling edges, full at 15 entries.
   logic [7:0] fmem [16];
   logic [3:0] wp, rp;
   logic [4:0] fcnt;
   logic       ien_d, oen_d, push, pop;

   assign push             = ien_d & ~bus.fifo_ien & (fcnt != 5'd15);
   assign pop              = oen_d & ~bus.fifo_oen & (fcnt != 5'd0);
   assign bus.fifo_full_n  = (fcnt != 5'd15);
   assign bus.fifo_empty_n = (fcnt != 5'd0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wp            <= '0;
         rp            <= '0;
         fcnt          <= '0;
         ien_d         <= 1'b0;
         oen_d         <= 1'b0;
         bus.fifo_odat <= '0;
      end else begin
         ien_d <= bus.fifo_ien;
         oen_d <= bus.fifo_oen;
         if (push) begin
            fmem[wp] <= bus.fifo_idat;
            wp       <= wp + 4'd1;
         end
         if (pop) begin
            bus.fifo_odat <= fmem[rp];
            rp            <= rp + 4'd1;
         end
         fcnt <= fcnt + {4'd0, push} - {4'd0, pop};
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Starts and ends in IDLE; latency counted from the IDLE cycle holding the request.
   task automatic wr_byte(input logic [7:0] d);
      int lat;
      int ien_n;
      lat   = 0;
      ien_n = 0;
      bus.wr_req = 1'b1;
      bus.wr_dat = d;
      do begin
         step();
         lat++;
         if (bus.fifo_ien) ien_n++;
      end while (!bus.wr_ack && lat < 40);
      bus.wr_req = 1'b0;
      chk("wr_latency", lat, 4);
      chk("wr_ien_pulses", ien_n, 1);
      step();
      chk("wr_ack_one_cycle", bus.wr_ack, 1'b0);
   endtask

   task automatic rd_byte(input logic [7:0] d);
      int lat;
      int oen_n;
      lat   = 0;
      oen_n = 0;
      bus.rd_req = 1'b1;
      do begin
         step();
         lat++;
         if (bus.fifo_oen) oen_n++;
      end while (!bus.rd_ack && lat < 40);
      bus.rd_req = 1'b0;
      chk("rd_latency", lat, 4);
      chk("rd_oen_pulses", oen_n, 1);
      chk("rd_dat_at_ack", bus.rd_dat, d);
      step();
      chk("rd_ack_one_cycle", bus.rd_ack, 1'b0);
      chk("rd_dat_held", bus.rd_dat, d);
   endtask

   initial begin
      rst        = 1'b0;
      bus.wr_req = 1'b0;
      bus.wr_dat = 8'h00;
      bus.rd_req = 1'b0;
      #12;

      chk("rst_ien", bus.fifo_ien, 1'b0);
      chk("rst_oen", bus.fifo_oen, 1'b0);
      chk("rst_idat", bus.fifo_idat, 8'h00);
      chk("rst_rd_dat", bus.rd_dat, 8'h00);
      chk("rst_wr_ack", bus.wr_ack, 1'b0);
      chk("rst_rd_ack", bus.rd_ack, 1'b0);
      chk("rst_wr_err", bus.wr_err, 1'b0);
      chk("rst_rd_err", bus.rd_err, 1'b0);
      chk("rst_lvl", bus.lvl, 4'h0);
      chk("rst_busy", bus.busy, 1'b0);

      @(negedge clk);
      rst = 1'b1;
      step();

      // Single write of A5 followed cycle by cycle.
      bus.wr_req = 1'b1;
      bus.wr_dat = 8'hA5;
      step();
      chk("a5_c1_ien", bus.fifo_ien, 1'b1);
      chk("a5_c1_idat", bus.fifo_idat, 8'hA5);
      chk("a5_c1_busy", bus.busy, 1'b1);
      chk("a5_c1_oen", bus.fifo_oen, 1'b0);
      bus.wr_dat = 8'h5A;
      step();
      chk("a5_c2_ien", bus.fifo_ien, 1'b0);
      step();
      chk("a5_c3_ien", bus.fifo_ien, 1'b0);
      chk("a5_c3_ack", bus.wr_ack, 1'b0);
      chk("a5_c3_lvl", bus.lvl, 4'h0);
      step();
      chk("a5_c4_ack", bus.wr_ack, 1'b1);
      chk("a5_c4_lvl", bus.lvl, 4'h1);
      chk("a5_c4_empty_n", bus.fifo_empty_n, 1'b1);
      bus.wr_req = 1'b0;
      step();
      chk("a5_c5_ack", bus.wr_ack, 1'b0);
      chk("a5_c5_busy", bus.busy, 1'b0);
      chk("a5_c5_ien", bus.fifo_ien, 1'b0);
      rd_byte(8'hA5);
      chk("a5_lvl_back", bus.lvl, 4'h0);

      // Ordering through the FIFO.
      wr_byte(8'h11);
      wr_byte(8'h22);
      wr_byte(8'h33);
      chk("ord_lvl3", bus.lvl, 4'h3);
      rd_byte(8'h11);
      rd_byte(8'h22);
      rd_byte(8'h33);
      chk("ord_lvl0", bus.lvl, 4'h0);
      chk("ord_empty_n", bus.fifo_empty_n, 1'b0);

      // Half full, last grant = read, then both ports held.
      for (int i = 0; i < 9; i++) wr_byte(8'h40 + 8'(i));
      rd_byte(8'h40);
      chk("alt_lvl_pre", bus.lvl, 4'h8);
      bus.wr_req = 1'b1;
      bus.wr_dat = 8'hC0;
      bus.rd_req = 1'b1;
      n    = 0;
      acks = 0;
      rd_n = 0;
      for (int k = 0; k < 4; k++) begin
         ack_cyc[k] = -1;
         ack_rd[k]  = 1'bx;
      end
      while (acks < 4 && n < 60) begin
         step();
         n++;
         if (bus.wr_ack || bus.rd_ack) begin
            ack_cyc[acks] = n;
            ack_rd[acks]  = bus.rd_ack;
            acks++;
            if (bus.rd_ack) begin
               chk("alt_rd_dat", bus.rd_dat, 8'h41 + 8'(rd_n));
               rd_n++;
            end
            if (bus.wr_ack) bus.wr_dat = 8'hC1;
         end
      end
      bus.wr_req = 1'b0;
      bus.rd_req = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk("alt_ack_cycle", ack_cyc[k], 4 + 5 * k);
         chk("alt_ack_port", ack_rd[k], (k % 2 == 1));
      end
      step();
      chk("alt_idle_busy", bus.busy, 1'b0);
      chk("alt_lvl_post", bus.lvl, 4'h8);
      for (int i = 3; i < 9; i++) rd_byte(8'h40 + 8'(i));
      rd_byte(8'hC0);
      rd_byte(8'hC1);
      chk("alt_drain_lvl", bus.lvl, 4'h0);
      chk("alt_drain_empty_n", bus.fifo_empty_n, 1'b0);

      // Fill to full, then a blocked 16th write released by a read.
      for (int i = 0; i < 15; i++) wr_byte(8'h10 + 8'(i));
      chk("full_lvl", bus.lvl, 4'hF);
      chk("full_full_n", bus.fifo_full_n, 1'b0);
      bus.wr_req = 1'b1;
      bus.wr_dat = 8'hEE;
      cnt_a = 0;
      cnt_b = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (bus.wr_ack) cnt_a++;
         if (bus.fifo_ien) cnt_b++;
      end
      chk("full_no_ack", cnt_a, 0);
      chk("full_no_ien", cnt_b, 0);
      chk("full_busy", bus.busy, 1'b0);
      bus.rd_req = 1'b1;
      n = 0;
      do begin
         step();
         n++;
      end while (!bus.rd_ack && n < 40);
      bus.rd_req = 1'b0;
      chk("full_rd_latency", n, 4);
      chk("full_rd_dat", bus.rd_dat, 8'h10);
      chk("full_rd_lvl", bus.lvl, 4'hE);
      n     = 0;
      cnt_b = 0;
      do begin
         step();
         n++;
         if (bus.fifo_ien) cnt_b++;
      end while (!bus.wr_ack && n < 40);
      bus.wr_req = 1'b0;
      chk("full_wr_after_rd", n, 5);
      chk("full_wr_ien", cnt_b, 1);
      chk("full_wr_lvl", bus.lvl, 4'hF);
      step();

      // Reset during RELEASE of a write.
      @(negedge clk);
      rst = 1'b0;
      step();
      @(negedge clk);
      rst = 1'b1;
      step();
      chk("mid_pre_empty_n", bus.fifo_empty_n, 1'b0);
      bus.wr_req = 1'b1;
      bus.wr_dat = 8'h77;
      step();
      chk("mid_assert_ien", bus.fifo_ien, 1'b1);
      step();
      #2;
      rst = 1'b0;
      #1;
      chk("mid_ien", bus.fifo_ien, 1'b0);
      chk("mid_oen", bus.fifo_oen, 1'b0);
      chk("mid_busy", bus.busy, 1'b0);
      chk("mid_lvl", bus.lvl, 4'h0);
      chk("mid_wr_ack", bus.wr_ack, 1'b0);
      bus.wr_req = 1'b0;
      step();
      @(negedge clk);
      rst = 1'b1;
      cnt_a = 0;
      cnt_b = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (bus.wr_ack) cnt_a++;
         if (bus.fifo_ien) cnt_b++;
      end
      chk("mid_no_ack", cnt_a, 0);
      chk("mid_no_ien", cnt_b, 0);
      chk("mid_post_empty_n", bus.fifo_empty_n, 1'b0);
      chk("mid_post_lvl", bus.lvl, 4'h0);

      // Read request on an empty FIFO.
      bus.rd_req = 1'b1;
`ifdef FIFO_PORT_ARB_TIMEOUT_EN
      n     = 0;
      cnt_c = 0;
      do begin
         step();
         n++;
         if (bus.fifo_oen) cnt_c++;
      end while (!bus.rd_ack && n < 60);
      bus.rd_req = 1'b0;
      chk("tmo_cycles", n, 16);
      chk("tmo_rd_err", bus.rd_err, 1'b1);
      chk("tmo_no_oen", cnt_c, 0);
      chk("tmo_rd_dat", bus.rd_dat, 8'h00);
      chk("tmo_lvl", bus.lvl, 4'h0);
      step();
      chk("tmo_err_one_cycle", bus.rd_err, 1'b0);
      chk("tmo_ack_one_cycle", bus.rd_ack, 1'b0);
`else
      cnt_a = 0;
      cnt_b = 0;
      cnt_c = 0;
      for (int i = 0; i < 30; i++) begin
         step();
         if (bus.rd_ack) cnt_a++;
         if (bus.rd_err || bus.wr_err) cnt_b++;
         if (bus.fifo_oen) cnt_c++;
      end
      bus.rd_req = 1'b0;
      chk("empty_no_ack", cnt_a, 0);
      chk("empty_no_err", cnt_b, 0);
      chk("empty_no_oen", cnt_c, 0);
      chk("empty_busy", bus.busy, 1'b0);
      step();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
